// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, error width and issue FSM states shared by the FPU issue controller
package fpu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int FPU_ERR_W = 3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_e;
endpackage

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: command queue with extra-bit wrap pointers and no bypass path
module fpu_cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign rdata = mem_q[rd_q[AW-1:0]];
  // pointers advance only on a legal push or pop
  always_comb begin
    wr_d = push && !full ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop && !empty ? rd_q + (AW+1)'(1) : rd_q;
  end
  // pointer registers and storage write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FPU commands and runs the start/done handshake one op at a time
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int ACK_WIN = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_a,
  input  logic [31:0]          cmd_b,
  input  logic [TAG_W-1:0]     cmd_tag,
  output logic                 fpu_start,
  output logic [1:0]           fpu_opcode,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_z,
  input  logic [FPU_ERR_W-1:0] fpu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_z,
  output logic [FPU_ERR_W-1:0] rsp_error,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_timeout
);
  localparam int W = 2 + 64 + TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT > ACK_WIN ? TIMEOUT : ACK_WIN) + 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic pop, fin, to_hit, full, empty;
  logic [W-1:0] rdata;
  logic [1:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, rsp_z_q, rsp_z_d;
  logic [TAG_W-1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic [FPU_ERR_W-1:0] rsp_err_q, rsp_err_d;
  logic start_q, start_d, rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
  fpu_cmd_fifo #(.W(W), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !full),
    .pop   (pop),
    .wdata ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );
  assign cmd_ready = !full;
  assign fpu_start = start_q;
  assign fpu_opcode = op_q;
  assign fpu_a = a_q;
  assign fpu_b = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z = rsp_z_q;
  assign rsp_error = rsp_err_q;
  assign rsp_tag = rsp_tag_q;
  assign rsp_timeout = rsp_to_q;
  // next state, saturating wait counter, issue registers and response capture
  always_comb begin
    pop = state_q == S_IDLE && !empty && fpu_done;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    fin = state_q == S_WAIT_DONE && fpu_done;
    to_hit = (state_q == S_WAIT_BUSY && fpu_done && cnt_inc == CNT_W'(ACK_WIN)) ||
             (state_q == S_WAIT_DONE && !fpu_done && cnt_inc == CNT_W'(TIMEOUT));
    cnt_d = (state_q == S_WAIT_BUSY && fpu_done) || state_q == S_WAIT_DONE ? cnt_inc : '0;
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = pop ? S_ISSUE : S_IDLE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: state_d = !fpu_done ? S_WAIT_DONE : to_hit ? S_RESP : S_WAIT_BUSY;
      S_WAIT_DONE: state_d = fin || to_hit ? S_RESP : S_WAIT_DONE;
      S_RESP:      state_d = rsp_ready ? S_IDLE : S_RESP;
      default:     state_d = S_IDLE;
    endcase
    {op_d, a_d, b_d, tag_d} = pop ? rdata : {op_q, a_q, b_q, tag_q};
    start_d = pop;
    rsp_valid_d = fin || to_hit || (rsp_valid_q && !rsp_ready);
    rsp_z_d = fin ? fpu_z : to_hit ? '0 : rsp_z_q;
    rsp_err_d = fin ? fpu_error : to_hit ? '0 : rsp_err_q;
    rsp_tag_d = fin || to_hit ? tag_q : rsp_tag_q;
    rsp_to_d = fin ? 1'b0 : to_hit ? 1'b1 : rsp_to_q;
  end
  // FSM and registered outputs; reset abandons any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_z_q <= '0;
      rsp_err_q <= '0;
      rsp_tag_q <= '0;
      rsp_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      tag_q <= tag_d;
      start_q <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q <= rsp_z_d;
      rsp_err_q <= rsp_err_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_to_q <= rsp_to_d;
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized bench with a behavioural fpu stub and an in-order response scoreboard
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;
  localparam int CMD_DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int ACK_WIN = 4;
  localparam int TIMEOUT = 1024;
  typedef struct packed {
    logic [31:0] z;
    logic [2:0] err;
    logic [TAG_W-1:0] tag;
    logic to;
  } rsp_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [TAG_W-1:0] cmd_tag = 0;
  logic fpu_start, fpu_done = 1;
  logic [1:0] fpu_opcode;
  logic [31:0] fpu_a, fpu_b, fpu_z = 0, pend_z = 0;
  logic [2:0] fpu_error = 0, pend_err = 0;
  logic rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_z;
  logic [2:0] rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  int vectors = 0, miscompares = 0;
  int mode = 0, lat = 2, busy_cnt = 0, ready_mode = 1;
  bit rand_lat = 0;
  logic rnd_ready = 0, prev_start = 0, prev_hold = 0;
  int starts = 0, dbl_starts = 0, unstable = 0;
  rsp_t cur, prev_rsp, got_q[$], exp_q[$];

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.CMD_DEPTH(CMD_DEPTH), .TAG_W(TAG_W), .ACK_WIN(ACK_WIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .fpu_start(fpu_start), .fpu_opcode(fpu_opcode),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done), .fpu_z(fpu_z), .fpu_error(fpu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_error(rsp_error),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
  );

  assign rsp_ready = ready_mode == 2 ? rnd_ready : ready_mode == 1;
  assign cur = {rsp_z, rsp_error, rsp_tag, rsp_timeout};
  always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  // fpu transfer function: exact IEEE results for the directed vectors, a fixed scramble otherwise
  function automatic logic [34:0] fpu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_MUL && a == 32'h41280000 && b == 32'h40600000) return {32'h42130000, 3'd0};
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'd0};
    if (op == OP_SUB && a == 32'h40400000 && b == 32'h3F800000) return {32'h40000000, 3'd0};
    return {a ^ {b[15:0], b[31:16]} ^ {30'd0, op}, a[2:0] ^ b[2:0]};
  endfunction

  // fpu stub: mode 0 normal, 1 never drops done, 2 drops done and holds it low
  always @(posedge clk) begin
    if (rst) begin
      fpu_done <= 1;
      busy_cnt <= 0;
    end else if (fpu_start && mode != 1) begin
      fpu_done <= 0;
      fpu_z <= 32'hDEADBEEF;
      fpu_error <= 3'd7;
      busy_cnt <= rand_lat ? int'($urandom_range(0, 4)) : lat;
      {pend_z, pend_err} <= fpu_model(fpu_opcode, fpu_a, fpu_b);
    end else if (!fpu_done && mode != 2) begin
      if (busy_cnt == 0) begin
        fpu_done <= 1;
        fpu_z <= pend_z;
        fpu_error <= pend_err;
      end else busy_cnt <= busy_cnt - 1;
    end
  end

  // monitor: collects accepted responses, counts starts and protocol slips
  always @(posedge clk) begin
    if (rst) prev_hold <= 0;
    else begin
      if (fpu_start) starts <= starts + 1;
      if (fpu_start && prev_start) dbl_starts <= dbl_starts + 1;
      if (prev_hold && rsp_valid && cur != prev_rsp) unstable <= unstable + 1;
      if (prev_hold && !rsp_valid) unstable <= unstable + 1;
      if (rsp_valid && rsp_ready) got_q.push_back(cur);
      prev_hold <= rsp_valid && !rsp_ready;
      prev_rsp <= cur;
    end
    prev_start <= fpu_start;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input bit to);
    int k = 0;
    rsp_t e;
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = tag;
    while (!cmd_ready && k < 3000) begin
      step();
      k++;
    end
    vectors++;
    if (!cmd_ready) begin
      miscompares++;
      $display("FAIL push_accept: cmd_ready=0 after %0d cycles, required 1", k);
    end else begin
      {e.z, e.err} = to ? 35'd0 : fpu_model(op, a, b);
      e.tag = tag;
      e.to = to;
      exp_q.push_back(e);
    end
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < 3000) begin
      step();
      k++;
    end
    ok = got_q.size() >= n;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) step();
    vectors++;
    if ({rsp_valid, fpu_start, cmd_ready, rsp_timeout} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid/start/ready/to=%b required 0010", {rsp_valid, fpu_start, cmd_ready, rsp_timeout});
    end
    vectors++;
    if ({rsp_z, rsp_error, rsp_tag, fpu_opcode, fpu_a, fpu_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got z=%h err=%0d tag=%0d op=%0d a=%h b=%h required all 0", rsp_z, rsp_error, rsp_tag, fpu_opcode, fpu_a, fpu_b);
    end
    rst = 0;
    repeat (3) step();
    vectors++;
    if (fpu_start !== 0 || rsp_valid !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: got start=%b valid=%b required 0 0", fpu_start, rsp_valid);
    end
  endtask

  task automatic test_mul;
    int s0, k;
    bit ok;
    rsp_t r;
    s0 = starts;
    ready_mode = 1;
    push_cmd(OP_MUL, 32'h41280000, 32'h40600000, 4'd3, 0);
    step();
    vectors++;
    if ({fpu_start, fpu_opcode, fpu_a, fpu_b} !== {1'b1, OP_MUL, 32'h41280000, 32'h40600000}) begin
      miscompares++;
      $display("FAIL mul_issue: got start=%b op=%0d a=%h b=%h required 1 2 41280000 40600000", fpu_start, fpu_opcode, fpu_a, fpu_b);
    end
    step();
    vectors++;
    if (fpu_start !== 0) begin
      miscompares++;
      $display("FAIL mul_pulse: got start=%b one cycle later, required 0", fpu_start);
    end
    k = 0;
    while (fpu_done !== 0 && k < 20) begin
      step();
      k++;
    end
    while (fpu_done !== 1 && k < 40) begin
      step();
      k++;
    end
    vectors++;
    if (rsp_valid !== 0 || k >= 40) begin
      miscompares++;
      $display("FAIL mul_done_edge: got valid=%b waited=%0d, required valid 0 as done rises", rsp_valid, k);
    end
    step();
    vectors++;
    if (rsp_valid !== 1) begin
      miscompares++;
      $display("FAIL mul_rsp_latency: got valid=%b one cycle after done, required 1", rsp_valid);
    end
    wait_got(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mul_rsp: got no response, required 1");
    end else begin
      r = got_q.pop_front();
      if (r !== {32'h42130000, 3'd0, 4'd3, 1'b0}) begin
        miscompares++;
        $display("FAIL mul_rsp: got z=%h err=%0d tag=%0d to=%b required 42130000 0 3 0", r.z, r.err, r.tag, r.to);
      end
    end
    vectors++;
    if (starts - s0 != 1 || dbl_starts != 0) begin
      miscompares++;
      $display("FAIL mul_starts: got starts=%0d doubled=%0d required 1 0", starts - s0, dbl_starts);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    rsp_t r;
    ready_mode = 1;
    push_cmd(OP_ADD, 32'h3F800000, 32'h40000000, 4'd5, 0);
    push_cmd(OP_SUB, 32'h40400000, 32'h3F800000, 4'd6, 0);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses required 2", got_q.size());
    end else begin
      r = got_q.pop_front();
      if (r !== {32'h40400000, 3'd0, 4'd5, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_first: got z=%h tag=%0d required 40400000 5", r.z, r.tag);
      end
      vectors++;
      r = got_q.pop_front();
      if (r !== {32'h40000000, 3'd0, 4'd6, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_second: got z=%h tag=%0d required 40000000 6", r.z, r.tag);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_full;
    int s0, k;
    bit ok;
    rsp_t r, e;
    ready_mode = 0;
    s0 = starts;
    push_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, 4'd0, 0);
    k = 0;
    while (rsp_valid !== 1 && k < 100) begin
      step();
      k++;
    end
    for (int i = 1; i <= CMD_DEPTH; i++) push_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, TAG_W'(i), 0);
    vectors++;
    if (cmd_ready !== 0) begin
      miscompares++;
      $display("FAIL full_ready: got cmd_ready=%b after %0d queued pushes, required 0", cmd_ready, CMD_DEPTH);
    end
    repeat (10) step();
    vectors++;
    if (starts - s0 != 1 || cmd_ready !== 0) begin
      miscompares++;
      $display("FAIL full_hold: got starts=%0d ready=%b required 1 0", starts - s0, cmd_ready);
    end
    ready_mode = 1;
    wait_got(CMD_DEPTH + 1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL full_count: got %0d responses required %0d", got_q.size(), CMD_DEPTH + 1);
    end else begin
      for (int i = 0; i <= CMD_DEPTH; i++) begin
        r = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (r !== e) begin
          miscompares++;
          $display("FAIL full_rsp[%0d]: got %h required %h", i, r, e);
        end
      end
    end
  endtask

  task automatic test_ack_timeout;
    int s0, k;
    bit ok;
    rsp_t r, e;
    mode = 1;
    ready_mode = 1;
    s0 = starts;
    push_cmd(OP_ADD, $urandom, $urandom, 4'd9, 1);
    step();
    vectors++;
    if (fpu_start !== 1) begin
      miscompares++;
      $display("FAIL ack_start: got start=%b required 1", fpu_start);
    end
    k = 0;
    while (rsp_valid !== 1 && k < 50) begin
      step();
      k++;
    end
    vectors++;
    if (k != ACK_WIN + 1) begin
      miscompares++;
      $display("FAIL ack_window: got response %0d cycles after start, required %0d", k, ACK_WIN + 1);
    end
    mode = 0;
    push_cmd(OP_MUL, $urandom, $urandom, 4'd10, 0);
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ack_count: got %0d responses required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (r !== e) begin
          miscompares++;
          $display("FAIL ack_rsp[%0d]: got %h required %h", i, r, e);
        end
      end
    end
    vectors++;
    if (starts - s0 != 2) begin
      miscompares++;
      $display("FAIL ack_starts: got %0d starts required 2", starts - s0);
    end
  endtask

  task automatic test_done_timeout;
    int s0, k;
    bit ok;
    rsp_t r, e;
    mode = 2;
    ready_mode = 1;
    s0 = starts;
    push_cmd(OP_DIV, $urandom, $urandom, 4'd11, 1);
    push_cmd(OP_SUB, $urandom, $urandom, 4'd12, 0);
    vectors++;
    if (fpu_start !== 1) begin
      miscompares++;
      $display("FAIL hang_start: got start=%b required 1", fpu_start);
    end
    k = 0;
    while (rsp_valid !== 1 && k < TIMEOUT + 100) begin
      step();
      k++;
    end
    vectors++;
    if (k != TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL hang_timeout: got response %0d cycles after start, required %0d", k, TIMEOUT + 2);
    end
    repeat (20) step();
    vectors++;
    if (starts - s0 != 1) begin
      miscompares++;
      $display("FAIL hang_gate: got %0d starts while fpu busy, required 1", starts - s0);
    end
    mode = 0;
    wait_got(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hang_count: got %0d responses required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (r !== e) begin
          miscompares++;
          $display("FAIL hang_rsp[%0d]: got %h required %h", i, r, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int s0, k;
    bit ok;
    rsp_t r, e;
    mode = 0;
    lat = 30;
    ready_mode = 1;
    push_cmd(OP_ADD, $urandom, $urandom, 4'd1, 0);
    push_cmd(OP_SUB, $urandom, $urandom, 4'd2, 0);
    push_cmd(OP_MUL, $urandom, $urandom, 4'd3, 0);
    k = 0;
    while (fpu_done !== 0 && k < 20) begin
      step();
      k++;
    end
    repeat (5) step();
    rst = 1;
    step();
    vectors++;
    if ({rsp_valid, fpu_start, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midreset: got valid/start/ready=%b required 001", {rsp_valid, fpu_start, cmd_ready});
    end
    rst = 0;
    exp_q.delete();
    got_q.delete();
    s0 = starts;
    repeat (60) step();
    vectors++;
    if (got_q.size() != 0 || starts != s0) begin
      miscompares++;
      $display("FAIL midreset_stale: got %0d responses %0d starts after reset, required 0 0", got_q.size(), starts - s0);
    end
    lat = 2;
    push_cmd(OP_DIV, $urandom, $urandom, 4'd4, 0);
    wait_got(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midreset_recover: got no response required 1");
    end else begin
      r = got_q.pop_front();
      e = exp_q.pop_front();
      if (r !== e) begin
        miscompares++;
        $display("FAIL midreset_recover: got %h required %h", r, e);
      end
    end
  endtask

  task automatic test_random;
    localparam int N = 24;
    bit ok;
    rsp_t r, e;
    mode = 0;
    rand_lat = 1;
    ready_mode = 2;
    for (int i = 0; i < N; i++) begin
      push_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, TAG_W'(i), 0);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_got(N, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rand_count: got %0d responses required %0d", got_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        r = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (r !== e) begin
          miscompares++;
          $display("FAIL rand_rsp[%0d]: got %h required %h", i, r, e);
        end
      end
    end
    vectors++;
    if (unstable != 0 || dbl_starts != 0) begin
      miscompares++;
      $display("FAIL rand_protocol: got unstable=%0d doubled_starts=%0d required 0 0", unstable, dbl_starts);
    end
    rand_lat = 0;
    ready_mode = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_full();
    test_ack_timeout();
    test_done_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
